// File: rtl/arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module   : arbiter_rr
// Brief    : Round-robin drain of four upstream FIFOs into one downstream
//            FIFO. Two-cycle pop-to-push pipeline, downstream pause, one-cycle
//            mask on the last granted port, and a sticky protocol-error flag.
// Revision : 1.0 - initial release
// ============================================================================
module arbiter_rr #(
  parameter int DATA_WIDTH = 6,
  parameter int NUM_PORTS  = 4
) (
  input  logic                  clk,
  input  logic                  RESET,
  input  logic [NUM_PORTS-1:0]  fifo_empty_in,
  input  logic [DATA_WIDTH-1:0] data_in0,
  input  logic [DATA_WIDTH-1:0] data_in1,
  input  logic [DATA_WIDTH-1:0] data_in2,
  input  logic [DATA_WIDTH-1:0] data_in3,
  input  logic [NUM_PORTS-1:0]  valid_in,
  input  logic                  pause_in,
  output logic [NUM_PORTS-1:0]  pop_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  push_out,
  output logic [7:0]            word_cnt,
  output logic [1:0]            state_out,
  output logic                  err_out
);

  localparam int c_PTR_W = 2;

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_IDLE  = 2'd1,
    S_ARB   = 2'd2,
    S_PAUSE = 2'd3
  } state_t;

  state_t                  r_state;
  logic [NUM_PORTS-1:0]    r_pop;    // doubles as the one-decision mask
  logic [c_PTR_W-1:0]      r_ptr;
  logic [NUM_PORTS-1:0]    r_exp;    // port whose valid_in is due this cycle
  logic                    r_push;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [7:0]              r_cnt;
  logic                    r_err;

  logic [NUM_PORTS-1:0]    w_nonempty;
  logic [NUM_PORTS-1:0]    w_elig;
  logic [c_PTR_W-1:0]      w_grant;
  logic                    w_found;
  logic [NUM_PORTS-1:0]    w_grant_oh;
  logic                    w_hit;
  logic                    w_extra;
  logic                    w_missing;
  logic                    w_check;
  logic                    w_push;
  logic                    w_proto_err;
  logic [DATA_WIDTH-1:0]   w_sel_data;

  // The port popped on the last edge still shows a stale empty flag, so it
  // sits out one decision.
  assign w_nonempty = ~fifo_empty_in;
  assign w_elig     = w_nonempty & ~r_pop;

  // First eligible port searched upward from the round-robin pointer.
  always_comb begin
    w_grant = r_ptr;
    w_found = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!w_found && w_elig[r_ptr + i[c_PTR_W-1:0]]) begin
        w_grant = r_ptr + i[c_PTR_W-1:0];
        w_found = 1'b1;
      end
    end
  end

  assign w_grant_oh = {{(NUM_PORTS-1){1'b0}}, 1'b1} << w_grant;

  // State, grant and pointer updates. ARB only falls back to IDLE when every
  // port reports empty: a port hidden by the mask alone still has work, and
  // staying in ARB lets a lone port be served every other cycle.
  always_ff @(posedge clk) begin
    if (RESET) begin
      r_state <= S_INIT;
      r_pop   <= '0;
      r_ptr   <= '0;
    end else begin
      r_pop <= '0;
      case (r_state)
        S_INIT:  r_state <= S_IDLE;
        S_IDLE: begin
          if (!pause_in && (|w_elig)) r_state <= S_ARB;
        end
        S_ARB: begin
          if (pause_in) begin
            r_state <= S_PAUSE;
          end else if (w_found) begin
            r_pop <= w_grant_oh;
            r_ptr <= w_grant + 2'd1;
          end else if (!(|w_nonempty)) begin
            r_state <= S_IDLE;
          end
        end
        S_PAUSE: begin
          if (!pause_in) r_state <= S_IDLE;
        end
        default: r_state <= S_INIT;
      endcase
    end
  end

  // Protocol check on the returning word. The cycle right after reset is
  // ignored so a word popped before reset cannot raise an error.
  assign w_check     = (r_state != S_INIT);
  assign w_hit       = |(valid_in & r_exp);
  assign w_extra     = |(valid_in & ~r_exp);
  assign w_missing   = (|r_exp) && !w_hit;
  assign w_proto_err = w_check && (w_extra || w_missing);
  assign w_push      = w_check && w_hit && !w_extra;

  // Select the read data of the port whose word is due.
  always_comb begin
    w_sel_data = '0;
    if (r_exp[0])      w_sel_data = data_in0;
    else if (r_exp[1]) w_sel_data = data_in1;
    else if (r_exp[2]) w_sel_data = data_in2;
    else if (r_exp[3]) w_sel_data = data_in3;
  end

  // Forwarding pipeline: track the in-flight pop, push its word, count it.
  always_ff @(posedge clk) begin
    if (RESET) begin
      r_exp  <= '0;
      r_push <= 1'b0;
      r_data <= '0;
      r_cnt  <= '0;
      r_err  <= 1'b0;
    end else begin
      r_exp  <= r_pop;
      r_push <= w_push;
      if (w_push) begin
        r_data <= w_sel_data;
        r_cnt  <= r_cnt + 8'd1;
      end
      if (w_proto_err) r_err <= 1'b1;
    end
  end

  assign pop_out   = r_pop;
  assign push_out  = r_push;
  assign data_out  = r_data;
  assign word_cnt  = r_cnt;
  assign state_out = r_state;
  assign err_out   = r_err;

endmodule
`default_nettype wire
